tag_rx_symb_accum: RTL and testbench
====================================

// Module: tag_rx_symb_accum
// PURPOSE
//  Integrate-and-dump stage directly downstream of the tag RX controller.
//  - After the controller's location-sync trigger, sums baseband I/Q over each symbol period.
//  - Emits one complex sum per symbol on an AXI-stream output; tlast marks the final symbol of a frame.
//  - A 2-entry output FIFO absorbs host back-pressure.
// PARAMETERS
//  DATA_WIDTH     16    signed width of in_i/in_q
//  SAMP_PER_SYMB  4096  accepted samples per symbol (>=2, power of 2 not required)
//  NSYMB          64    symbols per frame (>=1)
//  OUT_WIDTH      32    width of each output component; must be >= ACC_WIDTH
//  ACC_WIDTH      localparam = DATA_WIDTH + $clog2(SAMP_PER_SYMB)
// PORTS
//  clk          in   1             clock
//  reset        in   1             synchronous, active-high reset
//  clear        in   1             synchronous flush (same effect as reset, one cycle)
//  start        in   1             frame start pulse (controller rx_trig rising edge)
//  in_tvalid    in   1             sample qualifier (controller rx_valid)
//  in_i         in   DATA_WIDTH    baseband I, two's complement
//  in_q         in   DATA_WIDTH    baseband Q, two's complement
//  o_tdata      out  2*OUT_WIDTH   {I_sum, Q_sum}, sign-extended
//  o_tvalid     out  1             output word valid
//  o_tlast      out  1             word is symbol NSYMB-1 of the frame
//  o_tready     in   1             downstream ready
//  busy         out  1             high in ACCUM state
//  overflow     out  1             sticky: a symbol result was dropped (FIFO full)
//  symb_count   out  16            index of the symbol being accumulated (debug)
// BEHAVIOUR
//  - Reset/clear:
//    - state=IDLE; accumulators, samp/symb counters and FIFO emptied.
//    - o_tvalid=0, o_tlast=0, o_tdata=0, busy=0, overflow=0, symb_count=0.
//  - FSM IDLE:
//    - start=1 -> ACCUM; samp_cnt=0, symb_cnt=0, acc_i=acc_q=0.
//    - in_tvalid is ignored while in IDLE.
//  - FSM ACCUM, on each cycle with in_tvalid=1:
//    - acc += sign-extended sample; samp_cnt increments.
//    - When samp_cnt==SAMP_PER_SYMB-1, dump:
//      - push {acc+sample, sample-inclusive} to the FIFO with last=(symb_cnt==NSYMB-1);
//      - clear acc to 0, samp_cnt=0, symb_cnt+1.
//      - If that was symbol NSYMB-1 -> IDLE.
//  - No-sample cycles: in_tvalid=0 cycles hold all accumulator and counter state (gaps are allowed).
//  - Latency: word enters FIFO on the dump edge. If the FIFO was empty, o_tvalid=1 the next cycle.
//  - Sum is exact:
//    - |sum| <= SAMP_PER_SYMB*2^(DATA_WIDTH-1) fits in ACC_WIDTH; no saturation or rounding.
//    - Output is sign-extended to OUT_WIDTH.
//  - Output handshake is AXI-stream:
//    - o_tdata/o_tlast are stable while o_tvalid & ~o_tready.
//    - A pop occurs on o_tvalid & o_tready.
//    - A push and a pop in the same cycle are both honoured.
//  - FIFO full (2 entries, no pop that cycle) at dump: the word is dropped and overflow sets.
//    - Counters still advance; frame timing is never stalled.
//  - start while in ACCUM:
//    - abort the current frame; the partial symbol is discarded with no word emitted;
//    - restart at symb 0 the same cycle; the FIFO contents are kept.
//  - start coincident with a dump edge: the dump is pushed, then the restart applies.
//  - Reset or clear mid-frame discards FIFO contents and the partial sum immediately.
// TESTING
//  - SAMP_PER_SYMB=8, NSYMB=4, in_i=100, in_q=-3 constant, o_tready=1:
//    - 4 words {800,-24}; tlast on word 4 only; busy falls after 32nd sample.
//  - Same run with in_tvalid toggling 1/0 every cycle:
//    - identical words; frame spans 64 cycles.
//  - Full-scale: in_i=-32768, in_q=32767, SAMP_PER_SYMB=4096:
//    - I_sum=-134217728, Q_sum=134213632, exact and sign-extended.
//  - o_tready=0 for the whole frame:
//    - first 2 words retained in order; words 3-4 dropped; overflow=1.
//    - After o_tready=1, exactly 2 words pop.
//  - start pulse after 3 samples of symbol 2:
//    - no partial word; next word is a fresh 8-sample sum with symb_count restarted at 0.
//  - reset asserted while the FIFO holds 1 word:
//    - o_tvalid=0 next cycle; all outputs at reset values; start after reset behaves as a fresh frame.

Source files
------------

// File: rtl/tag_rx_symb_accum.sv
// Integrate-and-dump of baseband I/Q over each symbol period after a frame start,
// emitting one complex sum per symbol through a 2-entry AXI-stream FIFO.
module tag_rx_symb_accum #(
  parameter int DATA_WIDTH    = 16,
  parameter int SAMP_PER_SYMB = 4096,
  parameter int NSYMB         = 64,
  parameter int OUT_WIDTH     = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   in_tvalid,
  input  logic [DATA_WIDTH-1:0]  in_i,
  input  logic [DATA_WIDTH-1:0]  in_q,
  output logic [2*OUT_WIDTH-1:0] o_tdata,
  output logic                   o_tvalid,
  output logic                   o_tlast,
  input  logic                   o_tready,
  output logic                   busy,
  output logic                   overflow,
  output logic [15:0]            symb_count
);

  localparam int CNT_WIDTH = $clog2(SAMP_PER_SYMB);
  localparam int ACC_WIDTH = DATA_WIDTH + CNT_WIDTH;

  typedef enum logic {IDLE, ACCUM} state_t;

  typedef struct packed {
    logic                        last;
    logic signed [ACC_WIDTH-1:0] i;
    logic signed [ACC_WIDTH-1:0] q;
  } word_t;

  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        samp_cnt_q, samp_cnt_d;
  logic [15:0]                 symb_cnt_q, symb_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
  word_t                       fifo_q [2];
  word_t                       fifo_d [2];
  logic                        rd_ptr_q, rd_ptr_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic [1:0]                  count_q, count_d;
  logic                        overflow_q, overflow_d;

  logic signed [DATA_WIDTH-1:0] in_i_s, in_q_s;
  logic signed [ACC_WIDTH-1:0]  sum_i, sum_q;
  logic                         pop, dump, push_ok, last_symb;

  assign in_i_s    = in_i;
  assign in_q_s    = in_q;
  assign sum_i     = acc_i_q + ACC_WIDTH'(in_i_s);
  assign sum_q     = acc_q_q + ACC_WIDTH'(in_q_s);
  assign pop       = (count_q != 2'd0) && o_tready;
  assign last_symb = (symb_cnt_q == 16'(NSYMB - 1));

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    symb_cnt_d = symb_cnt_q;
    acc_i_d    = acc_i_q;
    acc_q_d    = acc_q_q;
    fifo_d     = fifo_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    overflow_d = overflow_q;
    dump       = 1'b0;
    push_ok    = 1'b0;

    if (state_q == ACCUM && in_tvalid) begin
      acc_i_d    = sum_i;
      acc_q_d    = sum_q;
      samp_cnt_d = samp_cnt_q + 1'b1;
      if (samp_cnt_q == CNT_WIDTH'(SAMP_PER_SYMB - 1)) begin
        dump       = 1'b1;
        acc_i_d    = '0;
        acc_q_d    = '0;
        samp_cnt_d = '0;
        symb_cnt_d = symb_cnt_q + 16'd1;
        if (last_symb) state_d = IDLE;
      end
    end

    // A restart wins over the counter update but never over the dump push below.
    if (start) begin
      state_d    = ACCUM;
      samp_cnt_d = '0;
      symb_cnt_d = '0;
      acc_i_d    = '0;
      acc_q_d    = '0;
    end

    if (dump) begin
      if (count_q != 2'd2 || pop) begin
        fifo_d[wr_ptr_q] = '{last: last_symb, i: sum_i, q: sum_q};
        wr_ptr_d         = ~wr_ptr_q;
        push_ok          = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (pop) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= IDLE;
      samp_cnt_q <= '0;
      symb_cnt_q <= '0;
      acc_i_q    <= '0;
      acc_q_q    <= '0;
      fifo_q     <= '{default: '0};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      symb_cnt_q <= symb_cnt_d;
      acc_i_q    <= acc_i_d;
      acc_q_q    <= acc_q_d;
      fifo_q     <= fifo_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  word_t                       head;
  logic signed [ACC_WIDTH-1:0] head_i, head_q;
  logic signed [OUT_WIDTH-1:0] out_i, out_q;

  assign head   = fifo_q[rd_ptr_q];
  assign head_i = head.i;
  assign head_q = head.q;
  assign out_i  = OUT_WIDTH'(head_i);
  assign out_q  = OUT_WIDTH'(head_q);

  assign o_tvalid   = (count_q != 2'd0);
  assign o_tlast    = o_tvalid & head.last;
  assign o_tdata    = o_tvalid ? {out_i, out_q} : '0;
  assign busy       = (state_q == ACCUM);
  assign overflow   = overflow_q;
  assign symb_count = symb_cnt_q;

endmodule

// File: tb/tb_tag_rx_symb_accum.sv
// Scoreboard bench for tag_rx_symb_accum: a frame-level model queues expected words,
// a negedge monitor pops them on each output handshake.
module tb_tag_rx_symb_accum;

  localparam int DW   = 16;
  localparam int SPS  = 8;
  localparam int NS   = 4;
  localparam int OW   = 32;
  localparam int SPS2 = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, clear, start, in_tvalid, o_tready;
  logic [DW-1:0] in_i, in_q;
  logic [2*OW-1:0] o_tdata;
  logic          o_tvalid, o_tlast, busy, overflow;
  logic [15:0]   symb_count;

  logic          fs_clear, fs_start, fs_valid, fs_ready;
  logic [DW-1:0] fs_i, fs_q;
  logic [2*OW-1:0] fs_tdata;
  logic          fs_tvalid, fs_tlast, fs_busy, fs_overflow;
  logic [15:0]   fs_symb_count;

  tag_rx_symb_accum #(.DATA_WIDTH(DW), .SAMP_PER_SYMB(SPS), .NSYMB(NS), .OUT_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .clear(clear), .start(start), .in_tvalid(in_tvalid),
    .in_i(in_i), .in_q(in_q), .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast),
    .o_tready(o_tready), .busy(busy), .overflow(overflow), .symb_count(symb_count)
  );

  tag_rx_symb_accum #(.DATA_WIDTH(DW), .SAMP_PER_SYMB(SPS2), .NSYMB(1), .OUT_WIDTH(OW)) dut_fs (
    .clk(clk), .reset(reset), .clear(fs_clear), .start(fs_start), .in_tvalid(fs_valid),
    .in_i(fs_i), .in_q(fs_q), .o_tdata(fs_tdata), .o_tvalid(fs_tvalid), .o_tlast(fs_tlast),
    .o_tready(fs_ready), .busy(fs_busy), .overflow(fs_overflow), .symb_count(fs_symb_count)
  );

  typedef struct {
    bit     last;
    longint i;
    longint q;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Frame-level reference: sample count, symbol index, running sums, FIFO occupancy.
  bit     m_active;
  int     m_samp, m_symb, m_occ;
  longint m_si, m_sq;
  bit     m_ovf;
  bit     expect_rst_vals;

  task automatic cmp(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic modelReset();
    m_active = 0; m_samp = 0; m_symb = 0; m_occ = 0;
    m_si = 0; m_sq = 0; m_ovf = 0;
    expect_rst_vals = 1;
  endtask

  task automatic modelStep(input bit st, input bit v, input int si, input int sq,
                           input bit rdy, input bit rst, input bit clr);
    bit pop_m;
    bit last;
    pop_m = (m_occ > 0) && rdy && !rst && !clr;
    if (rst || clr) begin
      modelReset();
      exp_q.delete();
      return;
    end
    if (m_active && v) begin
      m_si += si;
      m_sq += sq;
      m_samp++;
      if (m_samp == SPS) begin
        last = (m_symb == NS - 1);
        if (m_occ < 2 || pop_m) begin
          exp_q.push_back('{last, m_si, m_sq});
          m_occ++;
        end else begin
          m_ovf = 1;
        end
        m_samp = 0; m_si = 0; m_sq = 0;
        m_symb++;
        if (last) m_active = 0;
      end
    end
    if (st) begin
      m_active = 1; m_samp = 0; m_symb = 0; m_si = 0; m_sq = 0;
    end
    if (pop_m) m_occ--;
  endtask

  task automatic checkOutput();
    cmp("busy", longint'(busy), longint'(m_active));
    cmp("overflow", longint'(overflow), longint'(m_ovf));
    cmp("symb_count", longint'(symb_count), longint'(m_symb));
    cmp("tvalid", longint'(o_tvalid), longint'(m_occ > 0));
    if (expect_rst_vals) begin
      cmp("tdata_reset", longint'(o_tdata), 0);
      cmp("tlast_reset", longint'(o_tlast), 0);
      expect_rst_vals = 0;
    end
  endtask

  task automatic applyStimulus(input bit st, input bit v, input int si, input int sq,
                               input bit rdy, input bit rst, input bit clr);
    @(posedge clk);
    #1;
    checkOutput();
    start     = st;
    in_tvalid = v;
    in_i      = DW'(si);
    in_q      = DW'(sq);
    o_tready  = rdy;
    reset     = rst;
    clear     = clr;
    modelStep(st, v, si, sq, rdy, rst, clr);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, rdy, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset && !clear && o_tvalid && o_tready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_word: got %h, expected no word", o_tdata);
      end else begin
        e = exp_q.pop_front();
        cmp("word_i", longint'($signed(o_tdata[2*OW-1:OW])), e.i);
        cmp("word_q", longint'($signed(o_tdata[OW-1:0])), e.q);
        cmp("word_last", longint'(o_tlast), longint'(e.last));
      end
    end
  end

  initial begin
    int     si, sq, t;
    bit     st, v, rdy, clr;
    longint fs_exp_i, fs_exp_q;

    reset = 1; clear = 0; start = 0; in_tvalid = 0; in_i = '0; in_q = '0; o_tready = 1;
    fs_clear = 0; fs_start = 0; fs_valid = 0; fs_i = '0; fs_q = '0; fs_ready = 1;
    modelReset();

    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);

    $display("[TB] constant frame, continuous samples");
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < SPS * NS; k++) applyStimulus(0, 1, 100, -3, 1, 0, 0);
    idle(4, 1);

    $display("[TB] constant frame, alternating sample gaps");
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 2 * SPS * NS; k++) applyStimulus(0, (k % 2) == 0, 100, -3, 1, 0, 0);
    idle(4, 1);

    $display("[TB] host stalled for a whole frame");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < SPS * NS; k++) applyStimulus(0, 1, 100 + k, -3 - k, 0, 0, 0);
    idle(3, 0);
    idle(6, 1);
    applyStimulus(0, 0, 0, 0, 1, 0, 1);

    $display("[TB] restart after 3 samples of symbol 2");
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 2 * SPS + 3; k++) applyStimulus(0, 1, 11 * k - 40, 5 - k, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < SPS * NS; k++) applyStimulus(0, 1, 7, -5, 1, 0, 0);
    idle(4, 1);

    $display("[TB] reset with one word held");
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < SPS; k++) applyStimulus(0, 1, 1000, -1000, 0, 0, 0);
    applyStimulus(0, 1, 1000, -1000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < SPS * NS; k++) applyStimulus(0, 1, k, -k, 1, 0, 0);
    idle(4, 1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 10; f++) begin
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      for (int c = 0; c < 300 && m_active; c++) begin
        st  = ($urandom_range(0, 149) == 0);
        v   = ($urandom_range(0, 3) != 0);
        rdy = ($urandom_range(0, 2) != 0);
        clr = ($urandom_range(0, 399) == 0);
        si  = int'($urandom_range(0, 65535)) - 32768;
        sq  = int'($urandom_range(0, 65535)) - 32768;
        applyStimulus(st, v, si, sq, rdy, 0, clr);
      end
      idle(6, 1);
    end
    cmp("queue_drained", longint'(exp_q.size()), 0);

    $display("[TB] full-scale symbol");
    @(posedge clk); #1;
    fs_start = 1;
    @(posedge clk); #1;
    fs_start = 0; fs_valid = 1; fs_i = 16'h8000; fs_q = 16'h7FFF;
    repeat (SPS2) @(posedge clk);
    #1;
    fs_valid = 0;
    t = 0;
    while (!fs_tvalid && t < 10) begin
      @(posedge clk); #1;
      t++;
    end
    fs_exp_i = longint'(SPS2) * -32768;
    fs_exp_q = longint'(SPS2) * 32767;
    cmp("fs_tvalid", longint'(fs_tvalid), 1);
    cmp("fs_i", longint'($signed(fs_tdata[2*OW-1:OW])), fs_exp_i);
    cmp("fs_q", longint'($signed(fs_tdata[OW-1:0])), fs_exp_q);
    cmp("fs_tlast", longint'(fs_tlast), 1);
    cmp("fs_busy", longint'(fs_busy), 0);
    cmp("fs_overflow", longint'(fs_overflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
